diff_in_lane_monitor: RTL and testbench
=======================================

Name: diff_in_lane_monitor

Overview:
- Sequencing and health controller for one differential input lane.
- Sits directly behind a differential input buffer with true and complement outputs (O/OB pair) and ahead of fabric logic.
- Synchronizes the pair, qualifies the lane (lock acquisition), deglitches data, detects invalid-pair faults and keeps a saturating error count.
- Fabric consumes D_OUT only while LOCKED=1.

Parameters:
- LOCK_CNT, 8: consecutive valid samples required to lock; legal range 1..255.
- FAULT_CNT, 4: consecutive invalid samples while locked that declare fault; legal range 1..255.
- FILT_LEN, 3: consecutive identical valid samples required to change D_OUT; legal range 1..15.
- ERR_WIDTH, 8: width of ERR_CNT.

Ports:
- CLK  input  1  rising-edge clock; only clock.
- RST  input  1  synchronous, active-high reset.
- EN  input  1  lane enable; 0 forces IDLE.
- O_IN  input  1  true output of the differential buffer; asynchronous to CLK.
- OB_IN  input  1  complement output of the differential buffer; asynchronous to CLK.
- CLR_ERR  input  1  single-cycle request: clear ERR_CNT and leave FAULT.
- D_OUT  output  1  filtered lane data.
- EDGE  output  1  one-cycle pulse when D_OUT changes.
- LOCKED  output  1  lane qualified.
- FAULT  output  1  lane faulted.
- ERR_CNT  output  ERR_WIDTH  saturating invalid-sample count.

Behaviour:
- Clocking and reset:
  - Single clock domain; reset is synchronous and active-high.
  - RST=1 at a CLK edge: state IDLE; sync flops, all run/filter counters, D_OUT, EDGE, LOCKED, FAULT and ERR_CNT all 0.
  - RST overrides every other input, including mid-lock and mid-fault.
- Synchronizer:
  - Two flops on each of O_IN and OB_IN. Stage-2 values (o_s, ob_s) form the sample.
  - Valid sample: o_s != ob_s. Invalid sample: o_s == ob_s.
- States: IDLE, ACQ, LOCK, FAULT. All outputs registered.
- IDLE:
  - LOCKED=0, FAULT=0; D_OUT held.
  - EN=1 -> ACQ at the next edge with vrun=0.
- ACQ:
  - Valid sample: vrun+1. Invalid sample: vrun=0.
  - When vrun reaches LOCK_CNT on this edge: go to LOCK, set LOCKED=1, load D_OUT=o_s (no EDGE), irun=0, filter count=0.
- LOCK:
  - Invalid sample: irun+1 and ERR_CNT+1.
  - Valid sample: irun=0.
  - When irun reaches FAULT_CNT: go to FAULT, LOCKED=0, FAULT=1.
- FAULT:
  - D_OUT held; ERR_CNT still counts invalid samples.
  - CLR_ERR=1 -> ACQ with vrun=0 and FAULT=0.
- EN=0 in ACQ, LOCK or FAULT: IDLE at the next edge; LOCKED and FAULT cleared; ERR_CNT held.
- Precedence: RST > EN=0 > CLR_ERR > counting/transition logic.
- ERR_CNT:
  - Saturates at 2^ERR_WIDTH-1 with no wrap.
  - CLR_ERR=1 sets it to 0 at the edge. A clear beats a same-edge increment (result 0).
  - CLR_ERR in IDLE, ACQ or LOCK clears the count only; no state change.
- Deglitch filter (LOCK state only):
  - A valid sample with o_s != D_OUT increments the filter count.
  - A valid sample with o_s == D_OUT, or any invalid sample, resets the filter count to 0.
  - On the edge where the count would reach FILT_LEN: D_OUT=o_s, EDGE=1 for exactly that cycle, count=0.
  - EDGE=0 in all other cycles and states.
- Latency: a stable new valid pair applied before edge 1 (while in LOCK) produces D_OUT/EDGE after edge FILT_LEN+2.
- ACQ entered from IDLE with inputs already long stable and valid: LOCKED rises after LOCK_CNT further edges.
- Counters are sized to hold their parameter value; no counter wraps.

Test Plan:
- Lock: defaults, pair O=1/OB=0 stable, RST released, EN=1 before edge 1 -> ACQ after edge 1; LOCKED=1 and D_OUT=1 after edge 9; EDGE stays 0.
- Filter: locked with D_OUT=1; pair driven to 0/1 for 2 samples, then 1/0 -> D_OUT stays 1, no EDGE. Pair held at 0/1 -> D_OUT=0 and a single-cycle EDGE 5 edges after the change.
- Fault: locked; pair forced 1/1 -> ERR_CNT reaches 4, FAULT=1, LOCKED=0 after the 4th invalid sample. 3 invalid samples then 1 valid -> no fault, ERR_CNT=3.
- Saturation/clear: ERR_WIDTH=2, hold pair invalid 6 samples -> ERR_CNT=3. CLR_ERR on the same edge as an invalid sample -> ERR_CNT=0; state FAULT->ACQ.
- Control precedence: EN=0 while in FAULT -> IDLE, FAULT=0, ERR_CNT retained. RST pulse mid-LOCK -> all outputs 0 after that edge.
- Acquisition restart: in ACQ, one invalid sample at vrun=7 -> vrun resets; LOCKED asserts only after 8 further consecutive valid samples.

Source files
------------

// File: rtl/diff_in_lane_monitor.sv
// Lane health monitor for one differential input buffer (O/OB pair).
// Synchronizes the pair, qualifies the lane before fabric may use it,
// deglitches the data, and counts invalid samples (O == OB) with saturation.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | lane disabled; outputs quiet, D_OUT held
// ST_ACQ   | counting consecutive valid samples toward lock
// ST_LOCK  | lane qualified; deglitch filter active, invalid runs tracked
// ST_FAULT | too many consecutive invalid samples; wait for CLR_ERR
module diff_in_lane_monitor #(
  parameter int LOCK_CNT  = 8,
  parameter int FAULT_CNT = 4,
  parameter int FILT_LEN  = 3,
  parameter int ERR_WIDTH = 8
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 EN,
  input  logic                 O_IN,
  input  logic                 OB_IN,
  input  logic                 CLR_ERR,
  output logic                 D_OUT,
  output logic                 EDGE,
  output logic                 LOCKED,
  output logic                 FAULT,
  output logic [ERR_WIDTH-1:0] ERR_CNT
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ACQ   = 2'd1;
  localparam logic [1:0] ST_LOCK  = 2'd2;
  localparam logic [1:0] ST_FAULT = 2'd3;

  // Counters hold their terminal value exactly; none ever wraps.
  localparam int VW = $clog2(LOCK_CNT + 1);
  localparam int IW = $clog2(FAULT_CNT + 1);
  localparam int FW = $clog2(FILT_LEN + 1);

  localparam logic [VW-1:0]        VRUN_TC = VW'(LOCK_CNT);
  localparam logic [IW-1:0]        IRUN_TC = IW'(FAULT_CNT);
  localparam logic [FW-1:0]        FILT_TC = FW'(FILT_LEN);
  localparam logic [ERR_WIDTH-1:0] ERR_MAX = '1;

  logic [1:0]           state;
  logic                 o_q1, ob_q1, o_s, ob_s;
  logic [VW-1:0]        vrun;
  logic [IW-1:0]        irun;
  logic [FW-1:0]        fcnt;

  logic                 sample_valid;
  logic [VW-1:0]        vrun_nxt;
  logic [IW-1:0]        irun_nxt;
  logic [FW-1:0]        fcnt_nxt;
  logic [ERR_WIDTH-1:0] err_inc;
  logic                 count_err;

  assign sample_valid = o_s ^ ob_s;
  assign vrun_nxt     = vrun + VW'(1);
  assign irun_nxt     = irun + IW'(1);
  assign fcnt_nxt     = fcnt + FW'(1);
  assign err_inc      = (ERR_CNT == ERR_MAX) ? ERR_CNT : ERR_CNT + ERR_WIDTH'(1);
  // Invalid samples only count once the lane has been qualified.
  assign count_err    = ((state == ST_LOCK) || (state == ST_FAULT)) && !sample_valid;

  // Two-flop synchronizer on each leg of the asynchronous pair.
  always_ff @(posedge CLK) begin
    if (RST) begin
      o_q1  <= 1'b0;
      ob_q1 <= 1'b0;
      o_s   <= 1'b0;
      ob_s  <= 1'b0;
    end else begin
      o_q1  <= O_IN;
      ob_q1 <= OB_IN;
      o_s   <= o_q1;
      ob_s  <= ob_q1;
    end
  end

  // Sequencing FSM with run counters, deglitch filter and error counter.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state   <= ST_IDLE;
      vrun    <= '0;
      irun    <= '0;
      fcnt    <= '0;
      D_OUT   <= 1'b0;
      EDGE    <= 1'b0;
      LOCKED  <= 1'b0;
      FAULT   <= 1'b0;
      ERR_CNT <= '0;
    end else begin
      EDGE <= 1'b0;
      if (!EN) begin
        // Disabling the lane drops qualification but keeps the error history.
        state  <= ST_IDLE;
        LOCKED <= 1'b0;
        FAULT  <= 1'b0;
        vrun   <= '0;
        irun   <= '0;
        fcnt   <= '0;
      end else begin
        // A clear wins over an increment landing on the same edge.
        if (CLR_ERR) begin
          ERR_CNT <= '0;
        end else if (count_err) begin
          ERR_CNT <= err_inc;
        end

        case (state)
          ST_IDLE: begin
            state <= ST_ACQ;
            vrun  <= '0;
          end

          ST_ACQ: begin
            if (!sample_valid) begin
              vrun <= '0;
            end else if (vrun_nxt == VRUN_TC) begin
              // Lock takes the current level directly; this is not a data edge.
              state  <= ST_LOCK;
              LOCKED <= 1'b1;
              D_OUT  <= o_s;
              vrun   <= '0;
              irun   <= '0;
              fcnt   <= '0;
            end else begin
              vrun <= vrun_nxt;
            end
          end

          ST_LOCK: begin
            if (!sample_valid) begin
              fcnt <= '0;
              if (irun_nxt == IRUN_TC) begin
                state  <= ST_FAULT;
                LOCKED <= 1'b0;
                FAULT  <= 1'b1;
                irun   <= '0;
              end else begin
                irun <= irun_nxt;
              end
            end else begin
              irun <= '0;
              if (o_s != D_OUT) begin
                if (fcnt_nxt == FILT_TC) begin
                  D_OUT <= o_s;
                  EDGE  <= 1'b1;
                  fcnt  <= '0;
                end else begin
                  fcnt <= fcnt_nxt;
                end
              end else begin
                fcnt <= '0;
              end
            end
          end

          ST_FAULT: begin
            if (CLR_ERR) begin
              state <= ST_ACQ;
              FAULT <= 1'b0;
              vrun  <= '0;
            end
          end

          default: begin
            state <= ST_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_diff_in_lane_monitor.sv
// Directed bench for diff_in_lane_monitor. A second instance with a 2-bit
// error counter shares all inputs to exercise saturation.
module tb_diff_in_lane_monitor;

  logic       clk = 1'b0;
  logic       rst, en, o_in, ob_in, clr_err;
  logic       d_out, edge_p, locked, fault;
  logic [7:0] err_cnt;
  logic       d_out_2, edge_p_2, locked_2, fault_2;
  logic [1:0] err_cnt_2;

  int n_checks = 0;
  int n_pass   = 0;
  logic edge_seen;

  always #5 clk = ~clk;

  diff_in_lane_monitor u_dut (
    .CLK(clk), .RST(rst), .EN(en), .O_IN(o_in), .OB_IN(ob_in), .CLR_ERR(clr_err),
    .D_OUT(d_out), .EDGE(edge_p), .LOCKED(locked), .FAULT(fault), .ERR_CNT(err_cnt)
  );

  diff_in_lane_monitor #(.ERR_WIDTH(2)) u_dut_2 (
    .CLK(clk), .RST(rst), .EN(en), .O_IN(o_in), .OB_IN(ob_in), .CLR_ERR(clr_err),
    .D_OUT(d_out_2), .EDGE(edge_p_2), .LOCKED(locked_2), .FAULT(fault_2), .ERR_CNT(err_cnt_2)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    else n_pass++;
  endtask

  // One clock edge, then settle so outputs are sampled away from the edge.
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      if (edge_p === 1'b1) edge_seen = 1'b1;
    end
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; o_in = 1'b1; ob_in = 1'b0; clr_err = 1'b0;
    edge_seen = 1'b0;
    tick(2);
    check("rst_locked", locked, 0);
    check("rst_fault", fault, 0);
    check("rst_dout", d_out, 0);
    check("rst_edge", edge_p, 0);
    check("rst_err", err_cnt, 0);

    // Lock: synchronizer pre-filled while idle, then enable.
    rst = 1'b0;
    tick(3);
    en = 1'b1;
    edge_seen = 1'b0;
    tick(8);
    check("lock_not_yet", locked, 0);
    tick(1);
    check("lock_locked", locked, 1);
    check("lock_dout", d_out, 1);
    check("lock_no_edge", edge_seen, 0);

    // Filter: two-sample glitch rejected.
    o_in = 1'b0; ob_in = 1'b1;
    tick(2);
    o_in = 1'b1; ob_in = 1'b0;
    edge_seen = 1'b0;
    tick(6);
    check("glitch_dout", d_out, 1);
    check("glitch_no_edge", edge_seen, 0);

    // Filter: sustained change lands 5 edges later as a single pulse.
    o_in = 1'b0; ob_in = 1'b1;
    tick(4);
    check("filt_e4_edge", edge_p, 0);
    check("filt_e4_dout", d_out, 1);
    tick(1);
    check("filt_e5_edge", edge_p, 1);
    check("filt_e5_dout", d_out, 0);
    tick(1);
    check("filt_e6_edge", edge_p, 0);
    check("filt_e6_dout", d_out, 0);

    // Fault: invalid pair, fault on the 4th invalid sample.
    o_in = 1'b1; ob_in = 1'b1;
    tick(5);
    check("flt3_err", err_cnt, 3);
    check("flt3_fault", fault, 0);
    check("flt3_locked", locked, 1);
    tick(1);
    check("flt4_err", err_cnt, 4);
    check("flt4_fault", fault, 1);
    check("flt4_locked", locked, 0);
    check("flt4_dout_held", d_out, 0);
    tick(2);
    check("sat_err8", err_cnt, 6);
    check("sat_err2", err_cnt_2, 3);

    // Clear on the same edge as an invalid sample: FAULT -> ACQ.
    clr_err = 1'b1;
    tick(1);
    clr_err = 1'b0;
    check("clr_err", err_cnt, 0);
    check("clr_err2", err_cnt_2, 0);
    check("clr_fault", fault, 0);
    check("clr_locked", locked, 0);

    // Relock, fault again, then disable while faulted.
    o_in = 1'b1; ob_in = 1'b0;
    tick(10);
    check("relock_locked", locked, 1);
    check("relock_dout", d_out, 1);
    o_in = 1'b1; ob_in = 1'b1;
    tick(6);
    check("refault_fault", fault, 1);
    check("refault_err", err_cnt, 4);
    en = 1'b0;
    tick(1);
    check("dis_fault", fault, 0);
    check("dis_locked", locked, 0);
    check("dis_err", err_cnt, 4);
    tick(2);
    check("idle_err_held", err_cnt, 4);

    // Relock, then reset pulse mid-lock.
    o_in = 1'b1; ob_in = 1'b0; en = 1'b1;
    tick(10);
    check("lock3_locked", locked, 1);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    check("rstmid_locked", locked, 0);
    check("rstmid_dout", d_out, 0);
    check("rstmid_err", err_cnt, 0);
    check("rstmid_fault", fault, 0);
    check("rstmid_edge", edge_p, 0);

    // After reset the synchronizer restarts from 0, costing one extra edge.
    tick(10);
    check("lock4_locked", locked, 1);
    o_in = 1'b1; ob_in = 1'b1;
    tick(3);
    o_in = 1'b1; ob_in = 1'b0;
    tick(5);
    check("inv3_err", err_cnt, 3);
    check("inv3_fault", fault, 0);
    check("inv3_locked", locked, 1);

    // Acquisition restart: invalid sample at vrun=7.
    en = 1'b0;
    tick(1);
    en = 1'b1;
    tick(1);
    tick(5);
    o_in = 1'b1; ob_in = 1'b1;
    tick(1);
    o_in = 1'b1; ob_in = 1'b0;
    tick(2);
    check("restart_e9", locked, 0);
    tick(7);
    check("restart_e16", locked, 0);
    tick(1);
    check("restart_e17", locked, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
